adpll_ref_sweep_monitor: RTL

//  Parametrised reference generator and lock monitor for ADPLL bring-up.
//  A phase accumulator produces ref_clk_o; its tuning word K is static, swept (saw or triangle) or frozen.

---
 rtl/adpll_ref_sweep_monitor.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/adpll_ref_sweep_monitor.sv
// -----------------------------------------------------------------------------
// adpll_ref_sweep_monitor
//
// Reference generator and lock monitor used while bringing up an ADPLL.
// A phase accumulator advanced by tuning word K produces ref_clk_o. K is either
// static, swept as a sawtooth or triangle between two bounds, or frozen.
// The ADPLL's signed phase error is qualified into a lock flag, the time it
// took to lock and the peak error magnitude seen since K last changed.
//
// Ports
//   fpga_clk_i     in   1            clock for the accumulator and all state
//   reset_n_i      in   1            asynchronous active-low reset
//   enable_i       in   1            0 = idle, 1 = run
//   mode_i         in   2            00 static, 01 saw, 10 triangle, 11 hold
//   k_start_i      in   ACCUM_WIDTH  static K / sweep lower bound
//   k_stop_i       in   ACCUM_WIDTH  sweep upper bound
//   k_step_i       in   ACCUM_WIDTH  sweep increment
//   dwell_i        in   DWELL_WIDTH  clocks per K step, 0 = never step
//   error_i        in   ERR_WIDTH    two's complement phase error
//   error_valid_i  in   1            single-cycle strobe qualifying error_i
//   ref_clk_o      out  1            registered accumulator MSB
//   k_val_o        out  ACCUM_WIDTH  K currently applied
//   locked_o       out  1            lock qualified
//   lock_time_o    out  TIMER_WIDTH  clocks from last K change/unlock to lock
//   peak_err_o     out  ERR_WIDTH    max |error_i| since last K change
//   step_done_o    out  1            single-cycle pulse for each K update
// -----------------------------------------------------------------------------
module adpll_ref_sweep_monitor #(
  parameter int ACCUM_WIDTH = 12,
  parameter int ERR_WIDTH   = 8,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_COUNT  = 16,
  parameter int DWELL_WIDTH = 16,
  parameter int TIMER_WIDTH = 24
) (
  input  logic                   fpga_clk_i,
  input  logic                   reset_n_i,
  input  logic                   enable_i,
  input  logic [1:0]             mode_i,
  input  logic [ACCUM_WIDTH-1:0] k_start_i,
  input  logic [ACCUM_WIDTH-1:0] k_stop_i,
  input  logic [ACCUM_WIDTH-1:0] k_step_i,
  input  logic [DWELL_WIDTH-1:0] dwell_i,
  input  logic [ERR_WIDTH-1:0]   error_i,
  input  logic                   error_valid_i,
  output logic                   ref_clk_o,
  output logic [ACCUM_WIDTH-1:0] k_val_o,
  output logic                   locked_o,
  output logic [TIMER_WIDTH-1:0] lock_time_o,
  output logic [ERR_WIDTH-1:0]   peak_err_o,
  output logic                   step_done_o
);

  localparam int CNT_WIDTH = $clog2(LOCK_COUNT + 1);
  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_SAW    = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_LOCKED, ST_STEP} state_t;

  state_t                 state_reg, state_next;
  logic [ACCUM_WIDTH-1:0] acc_reg, acc_next;
  logic                   ref_clk_reg;
  logic [ACCUM_WIDTH-1:0] k_val_reg, k_val_next;
  logic                   dir_reg, dir_next;          // 0 = up, 1 = down
  logic [DWELL_WIDTH-1:0] dwell_cnt_reg, dwell_cnt_next;
  logic [CNT_WIDTH-1:0]   lock_cnt_reg, lock_cnt_next;
  logic [TIMER_WIDTH-1:0] timer_reg, timer_next;
  logic [TIMER_WIDTH-1:0] lock_time_reg, lock_time_next;
  logic [ERR_WIDTH-1:0]   peak_reg, peak_next;
  logic                   locked_reg, locked_next;
  logic                   step_done_reg, step_done_next;

  // Helper terms shared by the FSM
  logic [ERR_WIDTH-1:0]   err_mag;
  logic                   err_in_tol;
  logic [ERR_WIDTH-1:0]   peak_upd;
  logic [TIMER_WIDTH-1:0] timer_inc;
  logic [CNT_WIDTH-1:0]   lock_cnt_inc;
  logic                   lock_reached;
  logic [DWELL_WIDTH:0]   dwell_cnt_inc;
  logic [DWELL_WIDTH:0]   dwell_last;
  logic                   dwell_active;
  logic                   dwell_hit;
  logic                   static_change;
  logic                   step_trigger;
  logic [ACCUM_WIDTH:0]   k_sum;
  logic [ACCUM_WIDTH:0]   k_floor;
  logic [ACCUM_WIDTH-1:0] k_new;
  logic                   dir_new;

  always_comb begin
    // Magnitude kept in ERR_WIDTH unsigned bits so the most negative code
    // maps to 2^(ERR_WIDTH-1) instead of overflowing.
    err_mag      = error_i[ERR_WIDTH-1] ? (~error_i + ERR_WIDTH'(1)) : error_i;
    err_in_tol   = (err_mag <= ERR_WIDTH'(LOCK_TOL));
    peak_upd     = (err_mag > peak_reg) ? err_mag : peak_reg;
    timer_inc    = (timer_reg == '1) ? timer_reg : timer_reg + TIMER_WIDTH'(1);
    lock_cnt_inc = lock_cnt_reg + CNT_WIDTH'(1);
    lock_reached = (lock_cnt_inc == CNT_WIDTH'(LOCK_COUNT));

    // The STEP cycle itself is the last clock of a dwell period, so the step
    // is requested when the incremented count reaches dwell_i-1. The >= keeps
    // the sweep moving if dwell_i is lowered below the running count.
    dwell_cnt_inc = {1'b0, dwell_cnt_reg} + (DWELL_WIDTH+1)'(1);
    dwell_last    = {1'b0, dwell_i} - (DWELL_WIDTH+1)'(1);
    dwell_active  = ((mode_i == MODE_SAW) || (mode_i == MODE_TRI)) && (dwell_i != '0);
    dwell_hit     = dwell_active && (dwell_cnt_inc >= dwell_last);
    static_change = (mode_i == MODE_STATIC) && (k_start_i != k_val_reg);
    step_trigger  = dwell_hit || static_change;

    // Next K, evaluated with the mode present during the STEP cycle.
    k_sum   = {1'b0, k_val_reg} + {1'b0, k_step_i};
    k_floor = {1'b0, k_start_i} + {1'b0, k_step_i};
    k_new   = k_val_reg;
    dir_new = dir_reg;
    if (mode_i == MODE_STATIC) begin
      k_new = k_start_i;
    end else if ((mode_i == MODE_SAW) || (mode_i == MODE_TRI)) begin
      if (k_start_i >= k_stop_i) begin
        k_new = k_start_i;
      end else if (k_step_i == '0) begin
        k_new = k_val_reg;
      end else if (mode_i == MODE_SAW) begin
        k_new = (k_sum > {1'b0, k_stop_i}) ? k_start_i : k_sum[ACCUM_WIDTH-1:0];
      end else if (!dir_reg) begin
        if (k_sum >= {1'b0, k_stop_i}) begin
          k_new   = k_stop_i;
          dir_new = 1'b1;
        end else begin
          k_new = k_sum[ACCUM_WIDTH-1:0];
        end
      end else begin
        if ({1'b0, k_val_reg} < k_floor) begin
          k_new   = k_start_i;
          dir_new = 1'b0;
        end else begin
          k_new = k_val_reg - k_step_i;
        end
      end
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg + k_val_reg;
    k_val_next     = k_val_reg;
    dir_next       = dir_reg;
    dwell_cnt_next = dwell_cnt_reg;
    lock_cnt_next  = lock_cnt_reg;
    timer_next     = timer_reg;
    lock_time_next = lock_time_reg;
    peak_next      = peak_reg;
    locked_next    = locked_reg;
    step_done_next = 1'b0;

    case (state_reg)
      ST_SETTLE: begin
        timer_next = timer_inc;
        if (error_valid_i) begin
          peak_next     = peak_upd;
          lock_cnt_next = err_in_tol ? lock_cnt_inc : '0;
        end
        if (dwell_active) begin
          dwell_cnt_next = dwell_hit ? '0 : dwell_cnt_reg + DWELL_WIDTH'(1);
        end
        // A K change takes priority over a lock qualified on the same clock.
        if (step_trigger) begin
          state_next     = ST_STEP;
          step_done_next = 1'b1;
        end else if (error_valid_i && err_in_tol && lock_reached) begin
          state_next     = ST_LOCKED;
          locked_next    = 1'b1;
          lock_time_next = timer_inc;
          lock_cnt_next  = '0;
        end
      end
      ST_LOCKED: begin
        if (error_valid_i) begin
          peak_next = peak_upd;
        end
        if (dwell_active) begin
          dwell_cnt_next = dwell_hit ? '0 : dwell_cnt_reg + DWELL_WIDTH'(1);
        end
        if (step_trigger) begin
          state_next     = ST_STEP;
          step_done_next = 1'b1;
          locked_next    = 1'b0;
        end else if (error_valid_i && !err_in_tol) begin
          state_next    = ST_SETTLE;
          locked_next   = 1'b0;
          lock_cnt_next = '0;
          timer_next    = '0;
        end
      end
      ST_STEP: begin
        k_val_next     = k_new;
        dir_next       = dir_new;
        peak_next      = '0;
        timer_next     = '0;
        lock_cnt_next  = '0;
        dwell_cnt_next = '0;
        locked_next    = 1'b0;
        state_next     = ST_SETTLE;
      end
      default: begin
        state_next = ST_SETTLE;
      end
    endcase

    // Idle values apply both while idling and on the clock that leaves any
    // running state, so locked_o drops together with the state change.
    if (!enable_i || (state_reg == ST_IDLE)) begin
      acc_next       = '0;
      k_val_next     = k_start_i;
      dir_next       = 1'b0;
      dwell_cnt_next = '0;
      lock_cnt_next  = '0;
      timer_next     = '0;
      locked_next    = 1'b0;
      step_done_next = 1'b0;
      state_next     = enable_i ? ST_SETTLE : ST_IDLE;
    end
  end

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg     <= ST_IDLE;
      acc_reg       <= '0;
      ref_clk_reg   <= 1'b0;
      k_val_reg     <= '0;
      dir_reg       <= 1'b0;
      dwell_cnt_reg <= '0;
      lock_cnt_reg  <= '0;
      timer_reg     <= '0;
      lock_time_reg <= '0;
      peak_reg      <= '0;
      locked_reg    <= 1'b0;
      step_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      ref_clk_reg   <= acc_reg[ACCUM_WIDTH-1];
      k_val_reg     <= k_val_next;
      dir_reg       <= dir_next;
      dwell_cnt_reg <= dwell_cnt_next;
      lock_cnt_reg  <= lock_cnt_next;
      timer_reg     <= timer_next;
      lock_time_reg <= lock_time_next;
      peak_reg      <= peak_next;
      locked_reg    <= locked_next;
      step_done_reg <= step_done_next;
    end
  end

  assign ref_clk_o   = ref_clk_reg;
  assign k_val_o     = k_val_reg;
  assign locked_o    = locked_reg;
  assign lock_time_o = lock_time_reg;
  assign peak_err_o  = peak_reg;
  assign step_done_o = step_done_reg;

endmodule
